seg7_scan_monitor: RTL and testbench

Monitors a time-multiplexed, active-low 7-segment display bus (digit-select lines plus one shared segment bus) and reconstructs the value shown on each digit. Each digit's pattern is debounced over a run of identical scan samples and decoded back to a 0-9 number, blank or invalid. Changes are reported through a single-entry valid/ready event port. It is the receive end of the segment encoders in the VGA card's status/debug path, used for on-chip loopback checking and for mirroring display contents to the host.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_monitor_if.sv | 19 +
 rtl/seg7_pattern_decode.sv | 24 ++
 rtl/seg7_scan_monitor.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_monitor.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: decoded kinds, the active-low digit pattern
// table used by both the encoders and this monitor, and tracker types.
package seg7_pkg;

  typedef enum logic [1:0] {
    KIND_NUMBER  = 2'd0,
    KIND_BLANK   = 2'd1,
    KIND_INVALID = 2'd2
  } seg7_kind_t;

  // Segment patterns are active-low on bits 6:0 (g..a); all-ones is a dark digit.
  localparam logic [6:0] SEG7_BLANK = 7'h7F;
  localparam logic [6:0] SEG7_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    TRK_IDLE   = 2'd0,
    TRK_TRACK  = 2'd1,
    TRK_LOCKED = 2'd2
  } trk_state_t;

  typedef struct packed {
    seg7_kind_t kind;
    logic [3:0] number;
    logic       dp;
  } seg7_entry_t;

endpackage

// File: rtl/seg7_scan_monitor_if.sv
// Change-event port of the scan monitor: one pending event, valid/ready transfer.
interface seg7_scan_monitor_if;
  logic                   evt_valid;
  logic                   evt_ready;
  logic [2:0]             evt_digit;
  seg7_pkg::seg7_kind_t   evt_kind;
  logic [3:0]             evt_number;
  logic                   evt_dp;

  modport master (
    output evt_valid, evt_digit, evt_kind, evt_number, evt_dp,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_digit, evt_kind, evt_number, evt_dp,
    output evt_ready
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern (g..a) into
// number / blank / invalid using the shared pattern table.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]  seg,
  output seg7_kind_t  kind,
  output logic [3:0]  number
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    kind   = KIND_INVALID;
    number = '0;
    if (seg == SEG7_BLANK) kind = KIND_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG7_DIGIT[i]) begin
        kind   = KIND_NUMBER;
        number = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Watches a multiplexed active-low 7-segment bus, debounces each digit's
// pattern, keeps a per-digit table and reports changes through one event slot.
module seg7_scan_monitor
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [7:0]            seg,
  seg7_scan_monitor_if.master   evt,
  output logic [4*DIGITS-1:0]   numbers,
  output logic [2*DIGITS-1:0]   kinds,
  output logic                  sel_err,
  output logic                  overrun,
  input  logic                  err_clr
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [DIGITS-1:0] an_q;
  logic [7:0]        seg_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= an;
      seg_q <= seg;
    end
  end

  logic       slot_valid;
  logic       slot_multi;
  logic [2:0] slot_idx;

  always_comb begin
    slot_valid = $onehot(~an_q);
    slot_multi = $countones(~an_q) > 1;
    slot_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) slot_idx = 3'(i);
    end
  end

  seg7_kind_t  dec_kind;
  logic [3:0]  dec_number;
  seg7_entry_t cur_entry;

  seg7_pattern_decode u_decode (
    .seg    (seg_q[6:0]),
    .kind   (dec_kind),
    .number (dec_number)
  );

  assign cur_entry = '{kind: dec_kind, number: dec_number, dp: ~seg_q[7]};

  // Tracker: a sample is "the same" only if both digit index and full seg byte match.
  trk_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       trk_idx, trk_idx_n;
  logic [7:0]       trk_seg, trk_seg_n;
  logic             commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TRK_IDLE;
      cnt     <= '0;
      trk_idx <= '0;
      trk_seg <= '1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      trk_idx <= trk_idx_n;
      trk_seg <= trk_seg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    trk_idx_n = trk_idx;
    trk_seg_n = trk_seg;
    commit    = 1'b0;
    if (!slot_valid) begin
      state_n = TRK_IDLE;
      cnt_n   = '0;
    end else if (state == TRK_IDLE || slot_idx != trk_idx || seg_q != trk_seg) begin
      state_n   = TRK_TRACK;
      cnt_n     = CNT_ONE;
      trk_idx_n = slot_idx;
      trk_seg_n = seg_q;
      if (CNT_ONE == CNT_MAX) begin
        commit  = 1'b1;
        state_n = TRK_LOCKED;
      end
    end else if (state == TRK_TRACK) begin
      cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      if (cnt_n == CNT_MAX) begin
        commit  = 1'b1;
        state_n = TRK_LOCKED;
      end
    end
  end

  // Entry table; the commit always targets the slot currently on the bus.
  seg7_entry_t table_q [DIGITS];
  seg7_entry_t old_entry;
  logic        evt_gen;

  always_comb begin
    old_entry = table_q[0];
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_idx == 3'(i)) old_entry = table_q[i];
    end
    evt_gen = commit && (cur_entry != old_entry);
  end

  // NOTE: the table is reset because its contents are visible on ports; BLANK matches a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        table_q[i] <= '{kind: KIND_BLANK, number: 4'd0, dp: 1'b0};
      end
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (commit && slot_idx == 3'(i)) table_q[i] <= cur_entry;
      end
    end
  end

  always_comb begin
    numbers = '0;
    kinds   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      numbers[4*i +: 4] = table_q[i].number;
      kinds[2*i +: 2]   = table_q[i].kind;
    end
  end

  // Event holder: a transfer frees the slot in the same cycle a new event may load.
  logic        evt_valid_q;
  seg7_entry_t evt_entry_q;
  logic [2:0]  evt_digit_q;
  logic        xfer;
  logic        drop;

  assign xfer = evt_valid_q & evt.evt_ready;
  assign drop = evt_gen & evt_valid_q & ~xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_entry_q <= '0;
      evt_digit_q <= '0;
      sel_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (evt_gen && (!evt_valid_q || xfer)) begin
        evt_valid_q <= 1'b1;
        evt_entry_q <= cur_entry;
        evt_digit_q <= slot_idx;
      end else if (xfer) begin
        evt_valid_q <= 1'b0;
      end
      sel_err <= err_clr ? 1'b0 : (sel_err | slot_multi);
      overrun <= err_clr ? 1'b0 : (overrun | drop);
    end
  end

  assign evt.evt_valid  = evt_valid_q;
  assign evt.evt_digit  = evt_digit_q;
  assign evt.evt_kind   = evt_entry_q.kind;
  assign evt.evt_number = evt_entry_q.number;
  assign evt.evt_dp     = evt_entry_q.dp;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Directed bench for seg7_scan_monitor: table-driven slot scans plus
// hand-written glitch, select-error, overrun and reset sequences.
module tb_seg7_scan_monitor;

  localparam logic [1:0] K_NUM = 2'd0;
  localparam logic [1:0] K_BLK = 2'd1;
  localparam logic [1:0] K_INV = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        err_clr;
  logic [15:0] numbers;
  logic [7:0]  kinds;
  logic        sel_err;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_monitor_if ifc ();

  seg7_scan_monitor #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .an      (an),
    .seg     (seg),
    .evt     (ifc),
    .numbers (numbers),
    .kinds   (kinds),
    .sel_err (sel_err),
    .overrun (overrun),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic [2:0] digit;
    logic [1:0] kind;
    logic [3:0] number;
    logic       dp;
    logic       evt;
  } vec_t;

  vec_t       vecs [14];
  logic [3:0] m_num  [4];
  logic [1:0] m_kind [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_table(input string tag);
    logic [15:0] en;
    logic [7:0]  ek;
    for (int i = 0; i < 4; i++) begin
      en[4*i +: 4] = m_num[i];
      ek[2*i +: 2] = m_kind[i];
    end
    check({tag, "_numbers"}, numbers, en);
    check({tag, "_kinds"}, kinds, ek);
  endtask

  task automatic check_evt(input string tag, input logic [2:0] d, input logic [1:0] k,
                           input logic [3:0] num, input logic dp);
    check({tag, "_valid"}, ifc.evt_valid, 1'b1);
    check({tag, "_digit"}, ifc.evt_digit, d);
    check({tag, "_kind"}, ifc.evt_kind, k);
    check({tag, "_number"}, ifc.evt_number, num);
    check({tag, "_dp"}, ifc.evt_dp, dp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_num[i]  = 4'd0;
      m_kind[i] = K_BLK;
    end
  endtask

  initial begin
    int         ev_cnt;
    int         ev_tick;
    int         bad0;
    logic [2:0] ev_digit;
    logic [1:0] ev_kind;
    logic [3:0] ev_num;
    logic       ev_dp;

    //            an       seg     dig   kind   num    dp    evt
    vecs[0]  = '{4'b1110, 8'hF9, 3'd0, K_NUM, 4'd1, 1'b0, 1'b1};
    vecs[1]  = '{4'b1101, 8'hA4, 3'd1, K_NUM, 4'd2, 1'b0, 1'b1};
    vecs[2]  = '{4'b1011, 8'hB0, 3'd2, K_NUM, 4'd3, 1'b0, 1'b1};
    vecs[3]  = '{4'b0111, 8'h99, 3'd3, K_NUM, 4'd4, 1'b0, 1'b1};
    vecs[4]  = '{4'b1110, 8'hF9, 3'd0, K_NUM, 4'd1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1101, 8'hA4, 3'd1, K_NUM, 4'd2, 1'b0, 1'b0};
    vecs[6]  = '{4'b1011, 8'hB0, 3'd2, K_NUM, 4'd3, 1'b0, 1'b0};
    vecs[7]  = '{4'b0111, 8'h99, 3'd3, K_NUM, 4'd4, 1'b0, 1'b0};
    vecs[8]  = '{4'b1110, 8'h00, 3'd0, K_NUM, 4'd8, 1'b1, 1'b1};
    vecs[9]  = '{4'b1101, 8'h7E, 3'd1, K_INV, 4'd0, 1'b1, 1'b1};
    vecs[10] = '{4'b1011, 8'hFF, 3'd2, K_BLK, 4'd0, 1'b0, 1'b1};
    vecs[11] = '{4'b1011, 8'h7F, 3'd2, K_BLK, 4'd0, 1'b1, 1'b1};
    vecs[12] = '{4'b0111, 8'h19, 3'd3, K_NUM, 4'd4, 1'b1, 1'b1};
    vecs[13] = '{4'b0111, 8'h99, 3'd3, K_NUM, 4'd4, 1'b0, 1'b1};

    // Reset and idle display
    rst_n = 1'b0;
    an = 4'b1111;
    seg = 8'hFF;
    err_clr = 1'b0;
    ifc.evt_ready = 1'b1;
    model_reset();
    tick(3);
    check("rst_evt_valid", ifc.evt_valid, 1'b0);
    check_table("rst");
    check("rst_sel_err", sel_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    tick(4);
    check("idle_evt_valid", ifc.evt_valid, 1'b0);
    check_table("idle");

    // Table-driven scan slots, 8 cycles each, consumer always ready
    for (int i = 0; i < 14; i++) begin
      an  = vecs[i].an;
      seg = vecs[i].seg;
      tick(4);
      check($sformatf("v%0d_pre_valid", i), ifc.evt_valid, 1'b0);
      tick(1);
      check($sformatf("v%0d_lat_valid", i), ifc.evt_valid, vecs[i].evt);
      if (vecs[i].evt)
        check_evt($sformatf("v%0d_evt", i), vecs[i].digit, vecs[i].kind, vecs[i].number, vecs[i].dp);
      m_num[vecs[i].digit]  = vecs[i].number;
      m_kind[vecs[i].digit] = vecs[i].kind;
      check_table($sformatf("v%0d", i));
      tick(3);
      check($sformatf("v%0d_post_valid", i), ifc.evt_valid, 1'b0);
    end

    // Glitch: 0xC0 for 3 cycles never commits; 0x80 commits once
    an = 4'b1110;
    seg = 8'hC0;
    ev_cnt = 0;
    ev_tick = 0;
    bad0 = 0;
    ev_digit = '0;
    ev_kind = '0;
    ev_num = '0;
    ev_dp = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      if (t == 4) seg = 8'h80;
      tick(1);
      if (ifc.evt_valid) begin
        ev_cnt++;
        ev_tick  = t;
        ev_digit = ifc.evt_digit;
        ev_kind  = ifc.evt_kind;
        ev_num   = ifc.evt_number;
        ev_dp    = ifc.evt_dp;
      end
      if (numbers[3:0] == 4'd0) bad0++;
    end
    check("glitch_evt_count", ev_cnt, 1);
    check("glitch_evt_cycle", ev_tick, 8);
    check("glitch_evt_digit", ev_digit, 3'd0);
    check("glitch_evt_kind", ev_kind, K_NUM);
    check("glitch_evt_number", ev_num, 4'd8);
    check("glitch_evt_dp", ev_dp, 1'b0);
    check("glitch_zero_seen", bad0, 0);
    m_num[0] = 4'd8;
    m_kind[0] = K_NUM;
    check_table("glitch");

    // Multiple digit selects: sel_err, no commit, err_clr priority
    an = 4'b1100;
    seg = 8'hF9;
    tick(2);
    check("sel_err_set", sel_err, 1'b1);
    check("sel_no_evt", ifc.evt_valid, 1'b0);
    an = 4'b1111;
    tick(1);
    check_table("sel");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("sel_err_clr", sel_err, 1'b0);
    an = 4'b1100;
    err_clr = 1'b1;
    tick(3);
    check("sel_clr_priority", sel_err, 1'b0);
    err_clr = 1'b0;
    tick(1);
    check("sel_err_reset", sel_err, 1'b1);
    an = 4'b1111;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("sel_err_clr2", sel_err, 1'b0);

    // Back-pressure: second event dropped, third loads with no bubble
    ifc.evt_ready = 1'b0;
    an = 4'b1101;
    seg = 8'hC0;
    tick(5);
    check_evt("ovr_first", 3'd1, K_NUM, 4'd0, 1'b0);
    check("ovr_not_yet", overrun, 1'b0);
    tick(3);
    an = 4'b1011;
    seg = 8'hA4;
    tick(8);
    check_evt("ovr_held", 3'd1, K_NUM, 4'd0, 1'b0);
    check("ovr_set", overrun, 1'b1);
    m_num[1] = 4'd0;
    m_kind[1] = K_NUM;
    m_num[2] = 4'd2;
    m_kind[2] = K_NUM;
    check_table("ovr");
    an = 4'b0111;
    seg = 8'hB0;
    tick(4);
    check_evt("ovr_before_xfer", 3'd1, K_NUM, 4'd0, 1'b0);
    ifc.evt_ready = 1'b1;
    tick(1);
    check_evt("ovr_nobubble", 3'd3, K_NUM, 4'd3, 1'b0);
    tick(1);
    check("ovr_drained", ifc.evt_valid, 1'b0);
    m_num[3] = 4'd3;
    check_table("ovr3");
    check("ovr_sticky", overrun, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);

    // Reset mid-TRACK with a pending event and sel_err raised
    an = 4'b1100;
    tick(2);
    ifc.evt_ready = 1'b0;
    an = 4'b1110;
    seg = 8'h82;
    tick(5);
    check_evt("mid_pending", 3'd0, K_NUM, 4'd6, 1'b0);
    check("mid_sel_err", sel_err, 1'b1);
    seg = 8'h92;
    tick(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", ifc.evt_valid, 1'b0);
    check("mid_rst_digit", ifc.evt_digit, 3'd0);
    check("mid_rst_kind", ifc.evt_kind, 2'd0);
    check("mid_rst_number", ifc.evt_number, 4'd0);
    check("mid_rst_dp", ifc.evt_dp, 1'b0);
    check("mid_rst_sel_err", sel_err, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check_table("mid_rst");
    an = 4'b1111;
    seg = 8'hFF;
    tick(1);
    rst_n = 1'b1;
    ifc.evt_ready = 1'b1;
    tick(1);
    check("post_rst_valid", ifc.evt_valid, 1'b0);

    // Latency from IDLE after reset
    an = 4'b1110;
    seg = 8'h92;
    tick(4);
    check("lat_pre_valid", ifc.evt_valid, 1'b0);
    check_table("lat_pre");
    tick(1);
    check_evt("lat_evt", 3'd0, K_NUM, 4'd5, 1'b0);
    m_num[0] = 4'd5;
    m_kind[0] = K_NUM;
    check_table("lat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
